// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - two-byte instruction fetch/decode stage of the 8-bit accumulator CPU
// Build option FD_ILLEGAL_TRAP_EN: opcodes 4'hC-4'hF trap to HALTED with illegal raised.
module fetch_decode #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [3:0]        opcode,
   output logic [ADDR_W-1:0] X,
   output logic [ADDR_W-1:0] pc,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   output logic              halted,
   output logic              illegal
);

   localparam logic [3:0] OP_HALT = 4'h7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_OP,
      S_REQ_X,
      S_ISSUE,
      S_HALTED
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [3:0]        opcode_q, opcode_d;
   logic [ADDR_W-1:0] x_q, x_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              redirect_pending_q, redirect_pending_d;
   logic [ADDR_W-1:0] redirect_target_q, redirect_target_d;

   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      opcode_d           = opcode_q;
      x_d                = x_q;
      halted_d           = halted_q;
      illegal_d          = illegal_q;
      redirect_pending_d = redirect_pending_q;
      redirect_target_d  = redirect_target_q;

      case (state_q)
         S_IDLE: begin
            if (pc_load) begin
               pc_d = pc_load_val;
            end
            state_d = S_REQ_OP;
         end

         S_REQ_OP, S_REQ_X: begin
            if (mem_ack) begin
               // A redirect seen during or at the end of the read discards the returned byte.
               if (pc_load || redirect_pending_q) begin
                  pc_d               = pc_load ? pc_load_val : redirect_target_q;
                  redirect_pending_d = 1'b0;
                  state_d            = S_REQ_OP;
               end else if (state_q == S_REQ_OP) begin
                  opcode_d = mem_rdata[3:0];
                  pc_d     = pc_q + ADDR_W'(1);
                  if (mem_rdata[3:0] == OP_HALT) begin
                     halted_d = 1'b1;
                     state_d  = S_HALTED;
                  end
`ifdef FD_ILLEGAL_TRAP_EN
                  else if (mem_rdata[3:0] >= 4'hC) begin
                     halted_d  = 1'b1;
                     illegal_d = 1'b1;
                     state_d   = S_HALTED;
                  end
`endif
                  else begin
                     state_d = S_REQ_X;
                  end
               end else begin
                  x_d     = ADDR_W'(mem_rdata);
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = S_ISSUE;
               end
            end else if (pc_load) begin
               // The request is never withdrawn; remember the latest target instead.
               redirect_pending_d = 1'b1;
               redirect_target_d  = pc_load_val;
            end
         end

         S_ISSUE: begin
            if (pc_load) begin
               pc_d    = pc_load_val;
               state_d = S_REQ_OP;
            end else if (op_ready) begin
               state_d = S_REQ_OP;
            end
         end

         S_HALTED: begin
            if (pc_load) begin
               pc_d      = pc_load_val;
               halted_d  = 1'b0;
               illegal_d = 1'b0;
               state_d   = S_REQ_OP;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= S_IDLE;
         pc_q               <= RESET_PC;
         opcode_q           <= '0;
         x_q                <= '0;
         halted_q           <= 1'b0;
         illegal_q          <= 1'b0;
         redirect_pending_q <= 1'b0;
         redirect_target_q  <= '0;
      end else begin
         state_q            <= state_d;
         pc_q               <= pc_d;
         opcode_q           <= opcode_d;
         x_q                <= x_d;
         halted_q           <= halted_d;
         illegal_q          <= illegal_d;
         redirect_pending_q <= redirect_pending_d;
         redirect_target_q  <= redirect_target_d;
      end
   end

   assign mem_req  = (state_q == S_REQ_OP) || (state_q == S_REQ_X);
   assign mem_addr = pc_q;
   assign op_valid = (state_q == S_ISSUE);
   assign opcode   = opcode_q;
   assign X        = x_q;
   assign pc       = pc_q;
   assign halted   = halted_q;

`ifdef FD_ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - scoreboard bench for fetch_decode with a variable-latency memory model
module tb_fetch_decode;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_ack = 1'b0;
   logic       op_valid;
   logic       op_ready = 1'b0;
   logic [3:0] opcode;
   logic [7:0] x_out;
   logic [7:0] pc;
   logic       pc_load = 1'b0;
   logic [7:0] pc_load_val = 8'h00;
   logic       halted;
   logic       illegal;

   always #5 clk = ~clk;

   fetch_decode #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .X(x_out), .pc(pc),
      .pc_load(pc_load), .pc_load_val(pc_load_val), .halted(halted), .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] x;
      logic [7:0] pc;
   } exp_t;

   logic [7:0] mem [256];
   exp_t       exp_q [$];
   logic [7:0] ack_log [$];
   int         checks = 0;
   int         failures = 0;
   int         ack_delay = 0;
   int         wait_cnt = 0;
   int         unstable = 0;
   bit         spurious = 1'b0;
   logic [7:0] held_addr = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic mem_fill();
      for (int i = 0; i < 256; i++) mem[i] = 8'h07;
   endtask

   // which: 0 = halted, 1 = op_valid
   task automatic wait_for(input int which, input string tag);
      int n = 0;
      while (n < 200 && !((which == 0) ? halted : op_valid)) begin
         tick();
         n++;
      end
      check(tag, (which == 0) ? halted : op_valid, 1);
   endtask

   task automatic do_reset(input int delay, input bit ready);
      reset       = 1'b1;
      pc_load     = 1'b0;
      pc_load_val = 8'h00;
      op_ready    = ready;
      ack_delay   = delay;
      spurious    = 1'b0;
      tick();
      tick();
      ack_log.delete();
      unstable = 0;
      reset    = 1'b0;
   endtask

   // memory responder: ack after ack_delay wait cycles, checks address stability while waiting
   initial forever begin
      tick();
      if (mem_req) begin
         if (wait_cnt > 0 && mem_addr !== held_addr) unstable++;
         held_addr = mem_addr;
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            ack_log.push_back(mem_addr);
            wait_cnt  = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'hEE;
            wait_cnt++;
         end
      end else begin
         mem_ack   = spurious;
         mem_rdata = 8'hA5;
         wait_cnt  = 0;
      end
   end

   // issue monitor: a handshake visible at negedge completes on the next posedge
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset && op_valid && op_ready) begin
         check("issue_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_opcode", opcode, e.op);
            check("issue_x", x_out, e.x);
            check("issue_pc", pc, e.pc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // reset values and minimum latency
      mem_fill();
      mem[0]    = 8'h01;
      mem[1]    = 8'h2A;
      op_ready  = 1'b1;
      ack_delay = 0;
      tick();
      tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_op_valid", op_valid, 0);
      check("rst_pc", pc, 8'h00);
      check("rst_opcode", opcode, 0);
      check("rst_x", x_out, 0);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);
      exp_q.push_back({4'h1, 8'h2A, 8'h02});
      reset = 1'b0;
      tick();
      tick();
      check("lat_not_early", op_valid, 0);
      tick();
      check("lat_op_valid", op_valid, 1);
      check("lat_pc", pc, 8'h02);
      wait_for(0, "t1_halt");
      check("t1_halt_pc", pc, 8'h03);
      check("t1_reads", ack_log.size(), 3);
      spurious = 1'b1;
      tick();
      tick();
      spurious = 1'b0;
      tick();
      check("spur_ack_pc", pc, 8'h03);
      check("spur_ack_halted", halted, 1);
      check("halt_no_req", mem_req, 0);
      check("t1_sb_empty", exp_q.size(), 0);

      // wait states on both bytes, then a stalled issue
      mem_fill();
      mem[0] = 8'h35;
      mem[1] = 8'h99;
      exp_q.push_back({4'h5, 8'h99, 8'h02});
      do_reset(3, 1'b0);
      wait_for(1, "t2_valid");
      check("t2_reads", ack_log.size(), 2);
      check("t2_addr0", ack_log[0], 8'h00);
      check("t2_addr1", ack_log[1], 8'h01);
      check("t2_addr_stable", unstable, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_valid", op_valid, 1);
         check("t2_hold_opcode", opcode, 4'h5);
         check("t2_hold_x", x_out, 8'h99);
      end
      op_ready = 1'b1;
      wait_for(0, "t2_halt");
      check("t2_sb_empty", exp_q.size(), 0);

      // redirect during a stalled operand read, back-to-back targets
      mem_fill();
      mem[8'h00] = 8'h01;
      mem[8'h01] = 8'h22;
      mem[8'h40] = 8'h03;
      mem[8'h41] = 8'h44;
      exp_q.push_back({4'h3, 8'h44, 8'h42});
      do_reset(3, 1'b1);
      for (int n = 0; n < 50 && !(mem_req && mem_addr == 8'h01); n++) tick();
      check("t3_in_req_x", mem_addr, 8'h01);
      pc_load     = 1'b1;
      pc_load_val = 8'h30;
      tick();
      pc_load_val = 8'h40;
      tick();
      pc_load = 1'b0;
      check("t3_req_held", {mem_req, mem_addr}, {1'b1, 8'h01});
      wait_for(0, "t3_halt");
      check("t3_reads", ack_log.size(), 5);
      check("t3_target_addr", ack_log[2], 8'h40);
      check("t3_addr_stable", unstable, 0);
      check("t3_pc", pc, 8'h43);
      check("t3_sb_empty", exp_q.size(), 0);

      // redirect in ISSUE without handshake: flush
      mem_fill();
      mem[8'h00] = 8'h01;
      mem[8'h01] = 8'h11;
      mem[8'h50] = 8'h02;
      mem[8'h51] = 8'h55;
      exp_q.push_back({4'h2, 8'h55, 8'h52});
      do_reset(0, 1'b0);
      wait_for(1, "t4a_valid");
      pc_load     = 1'b1;
      pc_load_val = 8'h50;
      tick();
      pc_load = 1'b0;
      check("t4a_flush", op_valid, 0);
      check("t4a_refetch", {mem_req, mem_addr}, {1'b1, 8'h50});
      op_ready = 1'b1;
      wait_for(0, "t4a_halt");
      check("t4a_pc", pc, 8'h53);
      check("t4a_sb_empty", exp_q.size(), 0);

      // redirect coinciding with the handshake: instruction consumed
      exp_q.push_back({4'h1, 8'h11, 8'h02});
      exp_q.push_back({4'h2, 8'h55, 8'h52});
      do_reset(0, 1'b0);
      wait_for(1, "t4b_valid");
      op_ready    = 1'b1;
      pc_load     = 1'b1;
      pc_load_val = 8'h50;
      tick();
      pc_load = 1'b0;
      check("t4b_consumed", exp_q.size(), 1);
      check("t4b_refetch", {mem_req, mem_addr}, {1'b1, 8'h50});
      wait_for(0, "t4b_halt");
      check("t4b_sb_empty", exp_q.size(), 0);

      // instruction straddling the PC wrap
      mem_fill();
      do_reset(0, 1'b1);
      wait_for(0, "t5_first_halt");
      check("t5_halt_pc", pc, 8'h01);
      mem[8'h00] = 8'h10;
      mem[8'hFF] = 8'h02;
      exp_q.push_back({4'h2, 8'h10, 8'h01});
      pc_load     = 1'b1;
      pc_load_val = 8'hFF;
      tick();
      pc_load = 1'b0;
      check("t5_halt_cleared", halted, 0);
      wait_for(0, "t5_halt");
      check("t5_pc", pc, 8'h02);
      check("t5_sb_empty", exp_q.size(), 0);

      // opcode 4'hD: trap or normal issue depending on build
      mem_fill();
      mem[0] = 8'h0D;
      mem[1] = 8'h77;
`ifdef FD_ILLEGAL_TRAP_EN
      do_reset(0, 1'b1);
      wait_for(0, "t6_halt");
      check("t6_illegal", illegal, 1);
      check("t6_pc", pc, 8'h01);
      check("t6_no_operand", ack_log.size(), 1);
      pc_load     = 1'b1;
      pc_load_val = 8'h80;
      tick();
      pc_load = 1'b0;
      check("t6_illegal_clear", illegal, 0);
`else
      exp_q.push_back({4'hD, 8'h77, 8'h02});
      do_reset(0, 1'b1);
      wait_for(0, "t6_halt");
      check("t6_illegal", illegal, 0);
      check("t6_pc", pc, 8'h03);
`endif
      check("t6_sb_empty", exp_q.size(), 0);

      // reset mid-fetch drops the request immediately
      mem_fill();
      do_reset(5, 1'b1);
      tick();
      tick();
      check("t7_req_before", mem_req, 1);
      reset = 1'b1;
      #1;
      check("t7_req_dropped", mem_req, 0);
      check("t7_pc", pc, 8'h00);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
